// File: rtl/ifu_align_buf.sv
// Fetch realignment buffer: slices aligned 32-bit fetch words into whole RVC/RV32 instructions with PC.
// Outputs are registered-state driven (plus flush gating); one instruction per cycle when not starved.
module ifu_align_buf #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_is_rvc,
   output logic [31:0] out_pc
);

   logic [2:0][15:0] hw_q, hw_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [31:0]      pc_q, pc_d;
   logic             drop_lo_q, drop_lo_d;

   logic             hw0_rvc;
   logic             consume;
   logic             accept;
   logic [1:0]       base;

   assign hw0_rvc    = (hw_q[0][1:0] != 2'b11);
   assign out_valid  = ~flush & (((cnt_q != 2'd0) & hw0_rvc) | (cnt_q >= 2'd2));
   // Gated by occupancy so the cleared slots after reset do not look like an RVC instruction.
   assign out_is_rvc = (cnt_q != 2'd0) & hw0_rvc;
   assign out_instr  = hw0_rvc ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
   assign out_pc     = pc_q;
   assign in_ready   = (cnt_q <= 2'd1) & ~flush;

   assign consume = out_valid & out_ready;
   assign accept  = in_valid & in_ready;

   always_comb begin
      hw_d      = hw_q;
      cnt_d     = cnt_q;
      pc_d      = pc_q;
      drop_lo_d = drop_lo_q;
      base      = cnt_q;

      if (flush) begin
         hw_d      = '0;
         cnt_d     = 2'd0;
         pc_d      = {redirect_pc[31:1], 1'b0};
         drop_lo_d = redirect_pc[1];
      end else begin
         if (consume) begin
            if (hw0_rvc) begin
               hw_d = {16'h0000, hw_q[2], hw_q[1]};
               base = cnt_q - 2'd1;
               pc_d = pc_q + 32'd2;
            end else begin
               hw_d = {32'h0000_0000, hw_q[2]};
               base = cnt_q - 2'd2;
               pc_d = pc_q + 32'd4;
            end
         end
         cnt_d = base;

         // Accept only happens with cnt<=1, so base is 0 or 1 here and the buffer never overflows.
         if (accept) begin
            if (drop_lo_q) begin
               if (base == 2'd0) hw_d[0] = in_word[31:16];
               else              hw_d[1] = in_word[31:16];
               cnt_d     = base + 2'd1;
               drop_lo_d = 1'b0;
            end else begin
               if (base == 2'd0) begin
                  hw_d[0] = in_word[15:0];
                  hw_d[1] = in_word[31:16];
               end else begin
                  hw_d[1] = in_word[15:0];
                  hw_d[2] = in_word[31:16];
               end
               cnt_d = base + 2'd2;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hw_q      <= '0;
         cnt_q     <= 2'd0;
         pc_q      <= {RESET_PC[31:1], 1'b0};
         drop_lo_q <= RESET_PC[1];
      end else begin
         hw_q      <= hw_d;
         cnt_q     <= cnt_d;
         pc_q      <= pc_d;
         drop_lo_q <= drop_lo_d;
      end
   end

endmodule

// File: tb/tb_ifu_align_buf.sv
// Directed self-checking bench for ifu_align_buf; inputs change 1ns after the rising edge, outputs sampled 2ns after.
module tb_ifu_align_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_is_rvc;
   logic [31:0] out_pc;

   int tests_run = 0;
   int failures  = 0;

   ifu_align_buf #(.RESET_PC(32'h8000_0000)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .flush(flush), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_is_rvc(out_is_rvc), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      #3;
      tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests_run++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tests_run++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
      tests_run++; if (out_is_rvc !== 1'b0) begin failures++; $display("FAIL reset_out_is_rvc got %b exp 0", out_is_rvc); end
      tests_run++; if (out_pc !== 32'h8000_0000) begin failures++; $display("FAIL reset_out_pc got %h exp 80000000", out_pc); end
      tick();
      rst = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
   endtask

   task automatic test_rv32_stream();
      apply_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_word = 32'h00A0_0093;
      #1;
      tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rv32_idle got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
      tick();
      in_word = 32'h0010_0113;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h00A0_0093) begin failures++; $display("FAIL rv32_first got v=%b %h exp v=1 00a00093", out_valid, out_instr); end
      tests_run++; if (out_pc !== 32'h8000_0000 || out_is_rvc !== 1'b0) begin failures++; $display("FAIL rv32_first_pc got %h rvc=%b exp 80000000 rvc=0", out_pc, out_is_rvc); end
      tests_run++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rv32_full_in_ready got %b exp 0", in_ready); end
      tick();
      #1;
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rv32_gap got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h0010_0113 || out_pc !== 32'h8000_0004) begin failures++; $display("FAIL rv32_second got v=%b %h pc %h exp v=1 00100113 pc 80000004", out_valid, out_instr, out_pc); end
      tick();
      #1;
      tests_run++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0008) begin failures++; $display("FAIL rv32_drained got v=%b pc %h exp v=0 pc 80000008", out_valid, out_pc); end
   endtask

   task automatic test_rvc_pair();
      apply_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_word = 32'h4501_4505;
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_4505 || out_is_rvc !== 1'b1 || out_pc !== 32'h8000_0000) begin failures++; $display("FAIL rvc_first got v=%b %h rvc=%b pc %h exp v=1 00004505 rvc=1 pc 80000000", out_valid, out_instr, out_is_rvc, out_pc); end
      tests_run++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rvc_cnt2_in_ready got %b exp 0", in_ready); end
      tick();
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_4501 || out_pc !== 32'h8000_0002) begin failures++; $display("FAIL rvc_second got v=%b %h pc %h exp v=1 00004501 pc 80000002", out_valid, out_instr, out_pc); end
      tests_run++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rvc_cnt1_in_ready got %b exp 1", in_ready); end
      tick();
      #1;
      tests_run++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0004) begin failures++; $display("FAIL rvc_drained got v=%b pc %h exp v=0 pc 80000004", out_valid, out_pc); end
   endtask

   task automatic test_straddle();
      apply_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_word = 32'h0093_4505;
      tick();
      in_word = 32'h0000_00A0;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_4505 || out_pc !== 32'h8000_0000) begin failures++; $display("FAIL straddle_rvc got v=%b %h pc %h exp v=1 00004505 pc 80000000", out_valid, out_instr, out_pc); end
      tick();
      #1;
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL straddle_wait got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h00A0_0093 || out_is_rvc !== 1'b0 || out_pc !== 32'h8000_0002) begin failures++; $display("FAIL straddle_rv32 got v=%b %h rvc=%b pc %h exp v=1 00a00093 rvc=0 pc 80000002", out_valid, out_instr, out_is_rvc, out_pc); end
      out_ready = 1'b0;
      tick();
   endtask

   task automatic test_flush_redirect();
      apply_reset();
      out_ready = 1'b1; flush = 1'b1; redirect_pc = 32'h8000_0102;
      #1;
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL flush_cycle got v=%b r=%b exp v=0 r=0", out_valid, in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b1; in_word = 32'h4505_FFFF;
      #1;
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_after got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_4505 || out_is_rvc !== 1'b1 || out_pc !== 32'h8000_0102) begin failures++; $display("FAIL flush_drop_lo got v=%b %h rvc=%b pc %h exp v=1 00004505 rvc=1 pc 80000102", out_valid, out_instr, out_is_rvc, out_pc); end
      tick();
      #1;
      tests_run++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0104) begin failures++; $display("FAIL flush_single_hw got v=%b pc %h exp v=0 pc 80000104", out_valid, out_pc); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h4501_4505;
      tick();
      in_word = 32'h00A0_0093;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_4505 || out_pc !== 32'h8000_0000 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got v=%b %h pc %h r=%b exp v=1 00004505 pc 80000000 r=0", i, out_valid, out_instr, out_pc, in_ready); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      tests_run++; if (out_instr !== 32'h0000_4505 || out_pc !== 32'h8000_0000) begin failures++; $display("FAIL bp_rel0 got %h pc %h exp 00004505 pc 80000000", out_instr, out_pc); end
      tick();
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_4501 || out_pc !== 32'h8000_0002 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_rel1 got v=%b %h pc %h r=%b exp v=1 00004501 pc 80000002 r=1", out_valid, out_instr, out_pc, in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h00A0_0093 || out_pc !== 32'h8000_0004) begin failures++; $display("FAIL bp_rel2 got v=%b %h pc %h exp v=1 00a00093 pc 80000004", out_valid, out_instr, out_pc); end
      tick();
      #1;
      tests_run++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0008) begin failures++; $display("FAIL bp_drained got v=%b pc %h exp v=0 pc 80000008", out_valid, out_pc); end
   endtask

   task automatic test_flush_collision();
      apply_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_word = 32'h4501_4505;
      tick();
      flush = 1'b1; redirect_pc = 32'h0000_1001; in_word = 32'h0010_0113;
      #1;
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL coll_cycle got v=%b r=%b exp v=0 r=0", out_valid, in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0000_1000) begin failures++; $display("FAIL coll_after got v=%b r=%b pc %h exp v=0 r=1 pc 00001000", out_valid, in_ready, out_pc); end
      in_valid = 1'b1; in_word = 32'h00A0_0093;
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h00A0_0093 || out_pc !== 32'h0000_1000) begin failures++; $display("FAIL coll_new got v=%b %h pc %h exp v=1 00a00093 pc 00001000", out_valid, out_instr, out_pc); end
      tick();
   endtask

   task automatic test_pc_wrap();
      apply_reset();
      out_ready = 1'b1; flush = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      flush = 1'b0; in_valid = 1'b1; in_word = 32'h0000_1234;
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_0000 || out_pc !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_pre got v=%b %h pc %h exp v=1 00000000 pc fffffffe", out_valid, out_instr, out_pc); end
      tick();
      #1;
      tests_run++; if (out_valid !== 1'b0 || out_pc !== 32'h0000_0000) begin failures++; $display("FAIL wrap_post got v=%b pc %h exp v=0 pc 00000000", out_valid, out_pc); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_word = 32'h4501_4505;
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got v=%b exp 1", out_valid); end
      #2;
      rst = 1'b1;
      #1;
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_pc !== 32'h8000_0000) begin failures++; $display("FAIL areset_now got v=%b r=%b %h pc %h exp v=0 r=1 00000000 pc 80000000", out_valid, in_ready, out_instr, out_pc); end
      tick();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rv32_stream();
      test_rvc_pair();
      test_straddle();
      test_flush_redirect();
      test_backpressure();
      test_flush_collision();
      test_pc_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
